// File: rtl/complemento_2_serial.sv
`default_nettype none
// ============================================================================
// Module      : complemento_2_serial
// Description : Bit-serial pass / one's / two's / absolute-value unit, LSB first,
//               with overflow and zero flags over valid/ready handshakes.
// Revision    : 1.0
// ============================================================================
module complemento_2_serial #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             out_zero
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [1:0]       c_mode_pass = 2'b00;
   localparam logic [1:0]       c_mode_ones = 2'b01;
   localparam logic [1:0]       c_mode_neg  = 2'b10;
   localparam logic [1:0]       c_mode_abs  = 2'b11;
   localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_op_sr;
   logic [WIDTH-1:0] r_res_sr;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_mode;
   logic             r_sign;
   logic             r_seen_one;

   logic             w_bit;
   logic             w_negating;
   logic             w_res_bit;
   logic [WIDTH-1:0] w_res_next;
   logic             w_ovf;

   // Serial two's complement: copy bits up to and including the first 1, invert the rest.
   always_comb begin
      w_bit      = r_op_sr[0];
      w_negating = (r_mode == c_mode_neg) || ((r_mode == c_mode_abs) && r_sign);
      w_res_bit  = w_bit;
      case (r_mode)
         c_mode_pass: w_res_bit = w_bit;
         c_mode_ones: w_res_bit = ~w_bit;
         default:     w_res_bit = (w_negating && r_seen_one) ? ~w_bit : w_bit;
      endcase
      w_res_next = {w_res_bit, r_res_sr[WIDTH-1:1]};
      w_ovf      = ((r_mode == c_mode_neg) || (r_mode == c_mode_abs)) && r_sign
                   && w_res_next[WIDTH-1];
   end

   assign in_ready = (r_state == ST_IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_op_sr    <= '0;
         r_res_sr   <= '0;
         r_cnt      <= '0;
         r_mode     <= c_mode_pass;
         r_sign     <= 1'b0;
         r_seen_one <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ovf    <= 1'b0;
         out_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op_sr    <= in_data;
                  r_mode     <= in_mode;
                  r_sign     <= in_data[WIDTH-1];
                  r_cnt      <= '0;
                  r_seen_one <= 1'b0;
                  r_state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_op_sr    <= r_op_sr >> 1;
               r_res_sr   <= w_res_next;
               r_seen_one <= r_seen_one | w_bit;
               r_cnt      <= r_cnt + CNT_W'(1);
               if (r_cnt == c_last_bit) begin
                  r_state   <= ST_DONE;
                  out_valid <= 1'b1;
                  out_data  <= w_res_next;
                  out_zero  <= (w_res_next == '0);
                  out_ovf   <= w_ovf;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_complemento_2_serial.sv
`default_nettype none
// Bench for complemento_2_serial: directed WIDTH=4 scenarios, random WIDTH=4 traffic,
// and an exhaustive WIDTH=8 sweep, all against an arithmetic reference model.
module tb_complemento_2_serial;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       iv4, ir4, ov4, or4, of4, oz4;
   logic [3:0] id4, od4;
   logic [1:0] im4;
   logic       iv8, ir8, ov8, or8, of8, oz8;
   logic [7:0] id8, od8;
   logic [1:0] im8;

   int total = 0;
   int bad   = 0;

   complemento_2_serial #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_mode(im4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_ovf(of4), .out_zero(oz4));

   complemento_2_serial #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
      .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_ovf(of8), .out_zero(oz8));

   // Reference: {ovf, zero, result[7:0]} from plain signed arithmetic.
   function automatic logic [9:0] model(input int w, input logic [7:0] d, input logic [1:0] m);
      int mask, x, sx, r;
      logic [7:0] res;
      logic ovf, zro;
      mask = (1 << w) - 1;
      x    = int'(d) & mask;
      sx   = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
      case (m)
         2'b00:   r = x;
         2'b01:   r = ~x;
         2'b10:   r = -sx;
         default: r = (sx < 0) ? -sx : sx;
      endcase
      r   = r & mask;
      res = r[7:0];
      ovf = m[1] && (x == (1 << (w - 1)));
      zro = (r == 0);
      return {ovf, zro, res};
   endfunction

   function automatic logic get_ir(input int w);
      return (w == 4) ? ir4 : ir8;
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 4) ? ov4 : ov8;
   endfunction

   task automatic set_in(input int w, input logic v, input logic [7:0] d, input logic [1:0] m);
      if (w == 4) begin iv4 = v; id4 = d[3:0]; im4 = m; end
      else        begin iv8 = v; id8 = d;      im8 = m; end
   endtask

   task automatic set_or(input int w, input logic v);
      if (w == 4) or4 = v; else or8 = v;
   endtask

   // Runs one transaction; lat = -1 signals a timeout.
   task automatic run_txn(input int w, input logic [7:0] d, input logic [1:0] m, input int hold,
                          output logic [7:0] od, output logic of, output logic oz,
                          output int lat, output logic rdy_after);
      int k;
      k = 0; od = '0; of = 1'b0; oz = 1'b0; rdy_after = 1'b1; lat = -1;
      while (!get_ir(w) && k < 50) begin @(posedge clk); #1; k++; end
      if (!get_ir(w)) return;
      set_in(w, 1'b1, d, m);
      @(posedge clk); #1;
      set_in(w, 1'b0, 8'h00, 2'b00);
      rdy_after = get_ir(w);
      lat = 0;
      while (!get_ov(w) && lat < 60) begin @(posedge clk); #1; lat++; end
      if (!get_ov(w)) begin lat = -1; return; end
      if (w == 4) begin od = {4'h0, od4}; of = of4; oz = oz4; end
      else        begin od = od8;         of = of8; oz = oz8; end
      repeat (hold) begin @(posedge clk); #1; end
      set_or(w, 1'b1);
      @(posedge clk); #1;
      set_or(w, 1'b0);
   endtask

   task automatic test_reset;
      logic [7:0] od; logic of, oz, ra; int lat;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", ir4); end
      total++; if ({ov4, od4, of4, oz4} !== 7'b0) begin
         bad++; $display("FAIL rst_outputs: got %b want 0000000", {ov4, od4, of4, oz4}); end
      rst = 1'b0; #1;
      total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", ir4); end
      run_txn(4, 8'h03, 2'b10, 0, od, of, oz, lat, ra);
      total++; if (ra !== 1'b0) begin bad++; $display("FAIL ready_drop: got %b want 0", ra); end
      total++; if (lat !== 4) begin bad++; $display("FAIL first_latency: got %0d want 4", lat); end
      total++; if ({of, oz, od[3:0]} !== 6'b00_1101) begin
         bad++; $display("FAIL neg_0011: got %b want 001101", {of, oz, od[3:0]}); end
   endtask

   typedef struct { logic [3:0] d; logic [1:0] m; logic [3:0] r; logic ovf; logic zro; } vec_t;

   task automatic test_directed;
      vec_t v[7];
      logic [7:0] od; logic of, oz, ra; int lat;
      v[0] = '{4'b1000, 2'b10, 4'b1000, 1'b1, 1'b0};
      v[1] = '{4'b1000, 2'b11, 4'b1000, 1'b1, 1'b0};
      v[2] = '{4'b0000, 2'b10, 4'b0000, 1'b0, 1'b1};
      v[3] = '{4'b1010, 2'b11, 4'b0110, 1'b0, 1'b0};
      v[4] = '{4'b0101, 2'b11, 4'b0101, 1'b0, 1'b0};
      v[5] = '{4'b0101, 2'b01, 4'b1010, 1'b0, 1'b0};
      v[6] = '{4'b1001, 2'b00, 4'b1001, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         run_txn(4, {4'h0, v[i].d}, v[i].m, 0, od, of, oz, lat, ra);
         total++;
         if ({lat == 4, od[3:0], of, oz} !== {1'b1, v[i].r, v[i].ovf, v[i].zro}) begin
            bad++;
            $display("FAIL directed_%0d: got lat=%0d data=%b ovf=%b zero=%b want lat=4 data=%b ovf=%b zero=%b",
                     i, lat, od[3:0], of, oz, v[i].r, v[i].ovf, v[i].zro);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] od; logic of, oz, ra; int lat, k;
      logic [3:0] held;
      k = 0;
      while (!ir4 && k < 50) begin @(posedge clk); #1; k++; end
      set_in(4, 1'b1, 8'h05, 2'b10);
      @(posedge clk); #1;
      set_in(4, 1'b0, 8'h00, 2'b00);
      k = 0;
      while (!ov4 && k < 60) begin @(posedge clk); #1; k++; end
      held = od4;
      total++; if ({ov4, held} !== 5'b1_1011) begin
         bad++; $display("FAIL bp_result: got %b want 11011", {ov4, held}); end
      set_in(4, 1'b1, 8'h00, 2'b00);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         total++;
         if ({ov4, od4, ir4} !== {1'b1, held, 1'b0}) begin
            bad++; $display("FAIL bp_hold_%0d: got %b want %b", c, {ov4, od4, ir4}, {1'b1, held, 1'b0});
         end
      end
      set_in(4, 1'b0, 8'h00, 2'b00);
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      total++; if ({ov4, ir4} !== 2'b01) begin
         bad++; $display("FAIL bp_release: got %b want 01", {ov4, ir4}); end
      run_txn(4, 8'h06, 2'b00, 0, od, of, oz, lat, ra);
      total++; if ({lat == 4, od[3:0], of, oz} !== 7'b1_0110_00) begin
         bad++; $display("FAIL bp_next: got lat=%0d data=%b want lat=4 data=0110", lat, od[3:0]); end
   endtask

   task automatic test_reset_mid_shift;
      logic [7:0] od; logic of, oz, ra; int lat, k;
      k = 0;
      while (!ir4 && k < 50) begin @(posedge clk); #1; k++; end
      set_in(4, 1'b1, 8'h06, 2'b10);
      @(posedge clk); #1;
      set_in(4, 1'b0, 8'h00, 2'b00);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1; #1;
      total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", ir4); end
      @(posedge clk); #1;
      total++; if ({ov4, od4, of4, oz4} !== 7'b0) begin
         bad++; $display("FAIL mid_rst_outputs: got %b want 0000000", {ov4, od4, of4, oz4}); end
      rst = 1'b0; #1;
      total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL mid_rst_idle: got %b want 1", ir4); end
      k = 0;
      for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (ov4) k++; end
      total++; if (k !== 0) begin bad++; $display("FAIL aborted_presented: got %0d valid cycles want 0", k); end
      run_txn(4, 8'h01, 2'b10, 0, od, of, oz, lat, ra);
      total++; if ({lat == 4, od[3:0], of, oz} !== 7'b1_1111_00) begin
         bad++; $display("FAIL after_abort: got lat=%0d data=%b ovf=%b zero=%b want lat=4 data=1111 ovf=0 zero=0",
                         lat, od[3:0], of, oz); end
   endtask

   task automatic test_random4;
      logic [7:0] od, d; logic of, oz, ra; logic [1:0] m; logic [9:0] e; int lat, h;
      for (int i = 0; i < 60; i++) begin
         d = 8'($urandom_range(0, 15));
         m = 2'($urandom_range(0, 3));
         h = int'($urandom_range(0, 3));
         e = model(4, d, m);
         run_txn(4, d, m, h, od, of, oz, lat, ra);
         total++;
         if ({lat == 4, of, oz, od} !== {1'b1, e}) begin
            bad++; $display("FAIL random4 d=%h m=%b: got lat=%0d ovf=%b zero=%b data=%h want ovf=%b zero=%b data=%h",
                            d, m, lat, of, oz, od, e[9], e[8], e[7:0]);
         end
      end
   endtask

   task automatic test_exhaustive8;
      logic [7:0] od; logic of, oz, ra; logic [9:0] e; int lat;
      for (int d = 0; d < 256; d++) begin
         for (int m = 0; m < 4; m++) begin
            e = model(8, 8'(d), 2'(m));
            run_txn(8, 8'(d), 2'(m), int'($urandom_range(0, 1)), od, of, oz, lat, ra);
            total++;
            if ({lat == 8, of, oz, od} !== {1'b1, e}) begin
               bad++; $display("FAIL exh8 d=%h m=%0d: got lat=%0d ovf=%b zero=%b data=%h want lat=8 ovf=%b zero=%b data=%h",
                               d, m, lat, of, oz, od, e[9], e[8], e[7:0]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      iv4 = 1'b0; id4 = '0; im4 = '0; or4 = 1'b0;
      iv8 = 1'b0; id8 = '0; im8 = '0; or8 = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_shift();
      test_random4();
      test_exhaustive8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
